// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle control unit.
//   state_t      - FSM states (IF, ID, EX, MEM, WB, PCINC, JALR2, HALT)
//   alu_class_t  - how the ALU op decoder interprets funct3/inst[30]
//   OP_*         - RV32 major opcodes recognised by the controller
//   ALU_*        - ALU operation codes driven on alu_op
//   SRC_A_*, SRC_B_*, WB_*, PC_SRC_*, ADDR_* - datapath mux selects
//   F3_B*        - branch funct3 encodings
`timescale 1ns/1ps
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_PCINC = 3'd5,
    S_JALR2 = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_SUB    = 2'd1,
    CLS_RTYPE  = 2'd2,
    CLS_IARITH = 2'd3
  } alu_class_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  localparam logic       SRC_A_PC    = 1'b0;
  localparam logic       SRC_A_RS1   = 1'b1;
  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic [1:0] WB_ALUOUT   = 2'd0;
  localparam logic [1:0] WB_MDR      = 2'd1;
  localparam logic [1:0] WB_ALU      = 2'd2;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;
  localparam logic       ADDR_PC       = 1'b0;
  localparam logic       ADDR_ALUOUT   = 1'b1;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/mc_alu_op_decode.sv
// mc_alu_op_decode: purely combinational ALU operation decoder.
//   op_class in  2  alu_class_t: forced ADD, forced SUB, R-type or I-arith
//   inst30   in  1  instruction bit 30 (SUB/ADD distinction, R-type only)
//   funct3   in  3  instruction funct3
//   alu_op   out 4  ALU operation code
// Unlisted funct3 combinations fall back to ADD.
`timescale 1ns/1ps
module mc_alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic       inst30,
  input  logic [2:0] funct3,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (op_class)
      CLS_SUB: alu_op = ALU_SUB;
      CLS_RTYPE: begin
        case ({inst30, funct3})
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0111: alu_op = ALU_AND;
          4'b0110: alu_op = ALU_OR;
          4'b0001: alu_op = ALU_SLL;
          4'b0100: alu_op = ALU_XOR;
          4'b0101: alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      // Immediate forms ignore bit 30: it belongs to the immediate field.
      CLS_IARITH: begin
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b100:  alu_op = ALU_XOR;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b001:  alu_op = ALU_SLL;
          3'b101:  alu_op = ALU_SRL;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM controller for a multicycle RV32 subset datapath.
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   inst       in   instruction register (opcode [6:0], funct3 [14:12], bit 30)
//   alu_bcond  in   ALU flags: [0] zero, [1] negative, [2] positive
//   mem_ready  in   memory access completes this cycle
//   halt_req   in   datapath halt request, looked at only in EX on ECALL
//   ir_write, pc_write, mem_read, mem_write, reg_write  out  datapath strobes
//   i_or_d     out  memory address select (PC / ALUOut)
//   alu_src_a  out  ALU A select (PC / rs1)
//   alu_src_b  out  ALU B select (rs2 / 4 / imm)
//   alu_op     out  ALU operation code
//   pc_source  out  next-PC select (live ALU / ALUOut)
//   wb_sel     out  register write data select (ALUOut / MDR / live ALU)
//   is_halted  out  registered halt flag
// Build option: define MC_ECALL_HALT_EN to let ECALL with halt_req stop the
// machine in HALT until reset; otherwise ECALL behaves as a NOP.
`timescale 1ns/1ps
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] inst,
  input  logic [2:0]  alu_bcond,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        pc_source,
  output logic [1:0]  wb_sel,
  output logic        is_halted
);

  state_t     state, state_next;
  alu_class_t alu_class;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_taken;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Fields the controller never looks at.
  logic unused_in;
  assign unused_in = ^{inst[31], inst[29:15], inst[11:7], alu_bcond[2], halt_req};

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = alu_bcond[0];
      F3_BNE:  br_taken = !alu_bcond[0];
      F3_BLT:  br_taken = alu_bcond[1];
      F3_BGE:  br_taken = !alu_bcond[1];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IF;
      is_halted <= 1'b0;
    end else begin
      state     <= state_next;
      is_halted <= (state_next == S_HALT);
    end
  end

  always_comb begin
    state_next = state;
    alu_class  = CLS_ADD;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = ADDR_PC;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    pc_source  = PC_SRC_ALU;
    wb_sel     = WB_ALUOUT;

    case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = S_ID;
        end
      end

      // PC+imm computed speculatively so ALUOut holds the branch/JAL target.
      S_ID: begin
        alu_src_b  = SRC_B_IMM;
        state_next = S_EX;
      end

      S_EX: begin
        case (opcode)
          OP_RTYPE: begin
            alu_src_a  = SRC_A_RS1;
            alu_class  = CLS_RTYPE;
            state_next = S_WB;
          end
          OP_IARITH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            alu_class  = CLS_IARITH;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_class = CLS_SUB;
            if (br_taken) begin
              pc_write   = 1'b1;
              pc_source  = PC_SRC_ALUOUT;
              state_next = S_IF;
            end else begin
              state_next = S_PCINC;
            end
          end
          // Link value PC+4 comes straight off the ALU; target from ALUOut.
          OP_JAL: begin
            alu_src_b  = SRC_B_FOUR;
            reg_write  = 1'b1;
            wb_sel     = WB_ALU;
            pc_write   = 1'b1;
            pc_source  = PC_SRC_ALUOUT;
            state_next = S_IF;
          end
          OP_JALR: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_IMM;
            state_next = S_JALR2;
          end
          OP_ECALL: begin
`ifdef MC_ECALL_HALT_EN
            state_next = halt_req ? S_HALT : S_PCINC;
`else
            state_next = S_PCINC;
`endif
          end
          default: state_next = S_PCINC;
        endcase
      end

      // Address stays on the ALU for the whole access, even while stalled.
      S_MEM: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        i_or_d    = ADDR_ALUOUT;
        if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          if (mem_ready) state_next = S_PCINC;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) state_next = S_WB;
        end
      end

      // Register write-back overlaps the PC+4 update.
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        state_next = S_IF;
      end

      S_PCINC: begin
        alu_src_b  = SRC_B_FOUR;
        pc_write   = 1'b1;
        state_next = S_IF;
      end

      S_JALR2: begin
        alu_src_b  = SRC_B_FOUR;
        reg_write  = 1'b1;
        wb_sel     = WB_ALU;
        pc_write   = 1'b1;
        pc_source  = PC_SRC_ALUOUT;
        state_next = S_IF;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_IF;
    endcase

    // Outputs are held quiet while reset is asserted so a pending memory
    // access is dropped in the same cycle the reset arrives.
    if (!reset_n) begin
      alu_class = CLS_ADD;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      i_or_d    = ADDR_PC;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_RS2;
      pc_source = PC_SRC_ALU;
      wb_sel    = WB_ALUOUT;
    end
  end

  mc_alu_op_decode u_alu_op_decode (
    .op_class (alu_class),
    .inst30   (inst[30]),
    .funct3   (funct3),
    .alu_op   (alu_op)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] inst;
  logic [2:0]  alu_bcond;
  logic        mem_ready;
  logic        halt_req;
  logic        ir_write, pc_write, mem_read, mem_write, reg_write;
  logic        i_or_d, alu_src_a, pc_source, is_halted;
  logic [1:0]  alu_src_b, wb_sel;
  logic [3:0]  alu_op;

  int applied;
  int miscompares;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } sb_t;
  sb_t sb_q[$];

  multicycle_control_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .inst      (inst),
    .alu_bcond (alu_bcond),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .i_or_d    (i_or_d),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_source (pc_source),
    .wb_sel    (wb_sel),
    .is_halted (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: ir,pcw,mr,mw,rw,iod,src_a,src_b[2],alu_op[4],pc_src,wb_sel[2],halted
  function automatic logic [16:0] o(input logic ir, input logic pcw, input logic mr,
                                    input logic mw, input logic rw, input logic iod,
                                    input logic sa, input logic [1:0] sb,
                                    input logic [3:0] op, input logic ps,
                                    input logic [1:0] wb, input logic h);
    return {ir, pcw, mr, mw, rw, iod, sa, sb, op, ps, wb, h};
  endfunction

  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000,
                         A_XOR = 4'b0111, A_SRL = 4'b1000;

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_SUB  = 32'h402081B3,
                          I_AND  = 32'h0020F1B3, I_XORI = 32'h0040C193,
                          I_SRLI = 32'h0020D193, I_BEQ  = 32'h00208463,
                          I_BNE  = 32'h00209463, I_LW   = 32'h0000A183,
                          I_SW   = 32'h0030A023, I_JAL  = 32'h008000EF,
                          I_JALR = 32'h000080E7, I_NOP7F = 32'h0000007F,
                          I_ECALL = 32'h00000073;

  logic [16:0] v_def, v_if_rdy, v_if_wait, v_id, v_wb_reg, v_wb_ld, v_br_t, v_br_n,
               v_pcinc, v_link, v_mem_ld, v_mem_st, v_halt;

  function automatic logic [16:0] ex_r(input logic [3:0] op);
    return o(0,0,0,0,0,0,1,2'd0,op,0,2'd0,0);
  endfunction

  function automatic logic [16:0] ex_i(input logic [3:0] op);
    return o(0,0,0,0,0,0,1,2'd2,op,0,2'd0,0);
  endfunction

  task automatic check();
    sb_t         e;
    logic [16:0] obs;
    e   = sb_q.pop_front();
    obs = {ir_write, pc_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a,
           alu_src_b, alu_op, pc_source, wb_sel, is_halted};
    applied++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic [31:0] i,
                      input logic [2:0] bc, input logic rdy, input logic hr,
                      input logic [16:0] exp);
    sb_t e;
    @(negedge clk);
    reset_n   = rn;
    inst      = i;
    alu_bcond = bc;
    mem_ready = rdy;
    halt_req  = hr;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    #1;
    check();
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    inst        = 32'h0;
    alu_bcond   = 3'b000;
    mem_ready   = 1'b0;
    halt_req    = 1'b0;

    v_def     = o(0,0,0,0,0,0,0,2'd0,A_ADD,0,2'd0,0);
    v_halt    = o(0,0,0,0,0,0,0,2'd0,A_ADD,0,2'd0,1);
    v_if_rdy  = o(1,0,1,0,0,0,0,2'd0,A_ADD,0,2'd0,0);
    v_if_wait = o(0,0,1,0,0,0,0,2'd0,A_ADD,0,2'd0,0);
    v_id      = o(0,0,0,0,0,0,0,2'd2,A_ADD,0,2'd0,0);
    v_wb_reg  = o(0,1,0,0,1,0,0,2'd1,A_ADD,0,2'd0,0);
    v_wb_ld   = o(0,1,0,0,1,0,0,2'd1,A_ADD,0,2'd1,0);
    v_br_t    = o(0,1,0,0,0,0,1,2'd0,A_SUB,1,2'd0,0);
    v_br_n    = o(0,0,0,0,0,0,1,2'd0,A_SUB,0,2'd0,0);
    v_pcinc   = o(0,1,0,0,0,0,0,2'd1,A_ADD,0,2'd0,0);
    v_link    = o(0,1,0,0,1,0,0,2'd1,A_ADD,1,2'd2,0);
    v_mem_ld  = o(0,0,1,0,0,1,1,2'd2,A_ADD,0,2'd0,0);
    v_mem_st  = o(0,0,0,1,0,1,1,2'd2,A_ADD,0,2'd0,0);

    // Reset: everything at defaults, even with mem_ready high.
    step("rst0", 0, I_ADD, 3'b000, 1, 0, v_def);
    step("rst1", 0, I_ADD, 3'b000, 1, 0, v_def);

    // add x3,x1,x2
    step("add_if", 1, I_ADD, 3'b000, 1, 0, v_if_rdy);
    step("add_id", 1, I_ADD, 3'b000, 1, 0, v_id);
    step("add_ex", 1, I_ADD, 3'b000, 1, 0, ex_r(A_ADD));
    step("add_wb", 1, I_ADD, 3'b000, 1, 0, v_wb_reg);

    // sub / and (R-type decode)
    step("sub_if", 1, I_SUB, 3'b000, 1, 0, v_if_rdy);
    step("sub_id", 1, I_SUB, 3'b000, 1, 0, v_id);
    step("sub_ex", 1, I_SUB, 3'b000, 1, 0, ex_r(A_SUB));
    step("sub_wb", 1, I_SUB, 3'b000, 1, 0, v_wb_reg);
    step("and_if", 1, I_AND, 3'b000, 1, 0, v_if_rdy);
    step("and_id", 1, I_AND, 3'b000, 1, 0, v_id);
    step("and_ex", 1, I_AND, 3'b000, 1, 0, ex_r(A_AND));
    step("and_wb", 1, I_AND, 3'b000, 1, 0, v_wb_reg);

    // xori / srli (I-arith decode)
    step("xori_if", 1, I_XORI, 3'b000, 1, 0, v_if_rdy);
    step("xori_id", 1, I_XORI, 3'b000, 1, 0, v_id);
    step("xori_ex", 1, I_XORI, 3'b000, 1, 0, ex_i(A_XOR));
    step("xori_wb", 1, I_XORI, 3'b000, 1, 0, v_wb_reg);
    step("srli_if", 1, I_SRLI, 3'b000, 1, 0, v_if_rdy);
    step("srli_id", 1, I_SRLI, 3'b000, 1, 0, v_id);
    step("srli_ex", 1, I_SRLI, 3'b000, 1, 0, ex_i(A_SRL));
    step("srli_wb", 1, I_SRLI, 3'b000, 1, 0, v_wb_reg);

    // beq taken, beq not taken, bne taken
    step("beqt_if", 1, I_BEQ, 3'b001, 1, 0, v_if_rdy);
    step("beqt_id", 1, I_BEQ, 3'b001, 1, 0, v_id);
    step("beqt_ex", 1, I_BEQ, 3'b001, 1, 0, v_br_t);
    step("beqn_if", 1, I_BEQ, 3'b100, 1, 0, v_if_rdy);
    step("beqn_id", 1, I_BEQ, 3'b100, 1, 0, v_id);
    step("beqn_ex", 1, I_BEQ, 3'b100, 1, 0, v_br_n);
    step("beqn_pcinc", 1, I_BEQ, 3'b100, 1, 0, v_pcinc);
    step("bne_if", 1, I_BNE, 3'b100, 1, 0, v_if_rdy);
    step("bne_id", 1, I_BNE, 3'b100, 1, 0, v_id);
    step("bne_ex", 1, I_BNE, 3'b100, 1, 0, v_br_t);

    // lw with fetch stall and two memory wait cycles
    step("lw_if_wait", 1, I_LW, 3'b000, 0, 0, v_if_wait);
    step("lw_if", 1, I_LW, 3'b000, 1, 0, v_if_rdy);
    step("lw_id", 1, I_LW, 3'b000, 1, 0, v_id);
    step("lw_ex", 1, I_LW, 3'b000, 1, 0, ex_i(A_ADD));
    step("lw_mem0", 1, I_LW, 3'b000, 0, 0, v_mem_ld);
    step("lw_mem1", 1, I_LW, 3'b000, 0, 0, v_mem_ld);
    step("lw_mem2", 1, I_LW, 3'b000, 1, 0, v_mem_ld);
    step("lw_wb", 1, I_LW, 3'b000, 1, 0, v_wb_ld);

    // sw completing normally
    step("sw_if", 1, I_SW, 3'b000, 1, 0, v_if_rdy);
    step("sw_id", 1, I_SW, 3'b000, 1, 0, v_id);
    step("sw_ex", 1, I_SW, 3'b000, 1, 0, ex_i(A_ADD));
    step("sw_mem", 1, I_SW, 3'b000, 1, 0, v_mem_st);
    step("sw_pcinc", 1, I_SW, 3'b000, 1, 0, v_pcinc);

    // jal, jalr
    step("jal_if", 1, I_JAL, 3'b000, 1, 0, v_if_rdy);
    step("jal_id", 1, I_JAL, 3'b000, 1, 0, v_id);
    step("jal_ex", 1, I_JAL, 3'b000, 1, 0, v_link);
    step("jalr_if", 1, I_JALR, 3'b000, 1, 0, v_if_rdy);
    step("jalr_id", 1, I_JALR, 3'b000, 1, 0, v_id);
    step("jalr_ex", 1, I_JALR, 3'b000, 1, 0, ex_i(A_ADD));
    step("jalr_2", 1, I_JALR, 3'b000, 1, 0, v_link);

    // unknown opcode 0x7F runs as NOP
    step("nop_if", 1, I_NOP7F, 3'b000, 1, 0, v_if_rdy);
    step("nop_id", 1, I_NOP7F, 3'b000, 1, 0, v_id);
    step("nop_ex", 1, I_NOP7F, 3'b000, 1, 0, v_def);
    step("nop_pcinc", 1, I_NOP7F, 3'b000, 1, 0, v_pcinc);

    // reset in the middle of a stalled store
    step("swr_if", 1, I_SW, 3'b000, 1, 0, v_if_rdy);
    step("swr_id", 1, I_SW, 3'b000, 1, 0, v_id);
    step("swr_ex", 1, I_SW, 3'b000, 0, 0, ex_i(A_ADD));
    step("swr_mem", 1, I_SW, 3'b000, 0, 0, v_mem_st);
    step("swr_rst0", 0, I_SW, 3'b000, 0, 0, v_def);
    step("swr_rst1", 0, I_SW, 3'b000, 0, 0, v_def);
    step("swr_rel_if", 1, I_SW, 3'b000, 0, 0, v_if_wait);

    // ecall with halt request
    step("ecall_if", 1, I_ECALL, 3'b000, 1, 1, v_if_rdy);
    step("ecall_id", 1, I_ECALL, 3'b000, 1, 1, v_id);
    step("ecall_ex", 1, I_ECALL, 3'b000, 1, 1, v_def);
`ifdef MC_ECALL_HALT_EN
    step("ecall_halt0", 1, I_ECALL, 3'b000, 1, 1, v_halt);
    step("ecall_halt1", 1, I_ECALL, 3'b000, 1, 1, v_halt);
    step("ecall_halt2", 1, I_ADD, 3'b000, 1, 0, v_halt);
`else
    step("ecall_pcinc", 1, I_ECALL, 3'b000, 1, 1, v_pcinc);
    step("ecall_if2", 1, I_ECALL, 3'b000, 1, 1, v_if_rdy);
    step("ecall_id2", 1, I_ECALL, 3'b000, 1, 1, v_id);
`endif
    step("end_rst", 0, I_ADD, 3'b000, 1, 0, v_def);
    step("end_if", 1, I_ADD, 3'b000, 1, 0, v_if_rdy);
    step("end_id", 1, I_ADD, 3'b000, 1, 0, v_id);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 inst  in  32  instruction register contents: opcode [6:0], funct3 [14:12], bit 30.
REQ-005 alu_bcond  in  3  ALU flags: [0] result==0, [1] result<0, [2] result>0.
REQ-006 mem_ready  in  1  memory access complete this cycle.
REQ-007 halt_req  in  1  datapath reports x17==10; sampled only in EX.
REQ-008 ir_write, pc_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-009 i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs1.
REQ-011 alu_src_b  out  2  ALU B operand: 0 = rs2, 1 = constant 4, 2 = imm.
REQ-012 alu_op  out  4  ALU op code: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0110, XOR 0111, SRL 1000.
REQ-013 pc_source  out  1  next-PC select: 0 = live ALU result, 1 = ALUOut.
REQ-014 wb_sel  out  2  register write data: 0 = ALUOut, 1 = MDR, 2 = live ALU result.
REQ-015 is_halted  out  1  registered; high once halted.

Function
REQ-016 The FSM SHALL have states IF, ID, EX, MEM, WB, PCINC, JALR2 and HALT; outputs are combinational from state, opcode, mem_ready and alu_bcond.
REQ-017 Output defaults: every strobe 0, alu_op ADD, all selects 0.
REQ-018 IF: mem_read=1, i_or_d=0. Stay in IF while mem_ready=0. On mem_ready=1: ir_write=1, go to ID.
REQ-019 ID: src_a=PC, src_b=imm, ADD, so that ALUOut holds the branch/JAL target; go to EX.
REQ-020 EX, R-type (0110011): src_a=rs1, src_b=rs2, alu_op from {inst[30],funct3}: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0001 SLL, 0100 XOR, 0101 SRL. Go to WB.
REQ-021 EX, I-arith (0010011): src_b=imm, alu_op from funct3 only: 000 ADD, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL. Go to WB.
REQ-022 EX, LW/SW (0000011/0100011): rs1+imm with ADD; go to MEM.
REQ-023 EX, branch (1100011): rs1-rs2 with SUB. Taken conditions by funct3: BEQ=bcond[0], BNE=!bcond[0], BLT=bcond[1], BGE=!bcond[1]. Taken: pc_write=1, pc_source=1, go to IF. Not taken: go to PCINC.
REQ-024 EX, JAL (1101111): PC+4 with reg_write=1, wb_sel=2, pc_write=1, pc_source=1; go to IF.
REQ-025 EX, JALR (1100111): rs1+imm; go to JALR2.
REQ-026 JALR2: PC+4 with reg_write=1, wb_sel=2, pc_write=1, pc_source=1; go to IF. Clearing target bit 0 is the datapath's job.
REQ-027 MEM: ALU holds rs1+imm and i_or_d=1.
  - LW: mem_read=1; on mem_ready go to WB.
  - SW: mem_write=1; on mem_ready go to PCINC.
  - mem_ready=0: stay in MEM with outputs unchanged.
REQ-028 WB: reg_write=1, wb_sel=1 for LW else 0; concurrently PC+4 (src_a=PC, src_b=1, ADD), pc_write=1, pc_source=0; go to IF.
REQ-029 PCINC: PC+4 with pc_write=1, pc_source=0, no reg_write; go to IF.
REQ-030 Any unlisted opcode SHALL execute as a NOP: ID, then EX, then PCINC.

Reset
REQ-031 While reset_n=0: state=IF, is_halted=0, and every output forced to its default, including mem_read=0.
REQ-032 Reset asserted in any state, including MEM with a pending access, SHALL abort immediately; the first cycle after release is IF.

Configuration
REQ-033 With MC_ECALL_HALT_EN defined: ECALL (1110011) in EX with halt_req=1 goes to HALT; is_halted=1 next edge; HALT is held with all strobes 0 until reset.
REQ-034 Without MC_ECALL_HALT_EN: ECALL goes to PCINC and is_halted stays 0.

Structure
REQ-035 Shared package mc_ctrl_pkg SHALL hold the state enum, opcode constants, alu_op codes and src/wb select constants.
REQ-036 Sub-module mc_alu_op_decode SHALL be purely combinational: (opcode class, inst[30], funct3) to alu_op.

Verification
REQ-037 add x3,x1,x2 (0x002081B3), mem_ready=1 → IF,ID,EX,WB (4 cycles); EX alu_op=0010, src_b=0; WB reg_write=1, wb_sel=0, pc_write=1.
REQ-038 beq (0x00208463): bcond=001 → EX pc_write=1, pc_source=1, back to IF after 3 cycles; bcond=100 → PCINC, then IF.
REQ-039 lw (0x0000A183) with mem_ready low 2 cycles in MEM → MEM held 3 cycles, mem_read=1, i_or_d=1; then WB with wb_sel=1.
REQ-040 ecall (0x00000073) with halt_req=1 → macro on: is_halted=1, no further ir_write; macro off: PCINC, is_halted=0.
REQ-041 reset_n low during sw MEM → mem_write=0 the same cycle; after release IF with mem_read=1.
REQ-042 opcode 0x7F → ID, EX, PCINC; reg_write=0 and mem_write=0 throughout.
